// File: rtl/timer_evt_pkg.sv
// Shared types, limits and a small index helper for the timer event scheduler.
package timer_evt_pkg;

  localparam int MAX_CH          = 16;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_sel_e;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } sched_state_e;

  // Adds an offset to a channel index, wrapping at n (base and off are both < n).
  function automatic int wrap_add(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/timer_edge_capture.sv
// One event channel: synchroniser, edge detect, pending/direction/overflow flags.
// Optional TIMER_EVT_TIMESTAMP_EN adds a timestamp captured with the pending flag.
module timer_edge_capture
  import timer_evt_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
`ifdef TIMER_EVT_TIMESTAMP_EN
  , parameter int TS_W = 16
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sig,
  input  logic            en,
  input  logic [1:0]      edge_sel,
  input  logic            offered,
  input  logic            accept,
  input  logic            ovf_clr,
`ifdef TIMER_EVT_TIMESTAMP_EN
  input  logic [TS_W-1:0] ts_now,
  output logic [TS_W-1:0] ts,
`endif
  output logic            pending,
  output logic            rise,
  output logic            overflow
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_prev;
  logic                   hit_rise;
  logic                   hit_fall;
  logic                   detect;
  logic                   take_dir;
  edge_sel_e              mode;

  assign mode     = edge_sel_e'(edge_sel);
  assign hit_rise = sync[SYNC_STAGES-1] & ~sync_prev;
  assign hit_fall = ~sync[SYNC_STAGES-1] & sync_prev;
  assign detect   = en & ((hit_rise & (mode == EDGE_RISE || mode == EDGE_BOTH)) |
                          (hit_fall & (mode == EDGE_FALL || mode == EDGE_BOTH)));
  // A new edge replaces the direction only when the slot is free or is being emptied now.
  assign take_dir = detect & (~pending | accept);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= '0;
      sync_prev <= 1'b0;
      pending   <= 1'b0;
      rise      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], sig};
      sync_prev <= sync[SYNC_STAGES-1];
      if (detect) begin
        pending <= 1'b1;
      end else if (accept || (!en && !offered)) begin
        pending <= 1'b0;
      end
      if (take_dir) begin
        rise <= hit_rise;
      end
      if (detect && pending && !accept) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef TIMER_EVT_TIMESTAMP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts <= '0;
    end else if (take_dir) begin
      ts <= ts_now;
    end
  end
`endif

endmodule

// File: rtl/timer_event_scheduler.sv
// Round-robin scheduler sharing one valid/ready event channel between NUM_CH timer inputs.
// Optional TIMER_EVT_TIMESTAMP_EN adds a free-running counter and the o_evt_ts output.
module timer_event_scheduler
  import timer_evt_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
`ifdef TIMER_EVT_TIMESTAMP_EN
  parameter int TS_W        = 16,
`endif
  localparam int ID_W       = $clog2(NUM_CH)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_CH-1:0]   i_ch_sig,
  input  logic [NUM_CH-1:0]   i_ch_en,
  input  logic [2*NUM_CH-1:0] i_edge_sel,
  input  logic                i_evt_ready,
  input  logic [NUM_CH-1:0]   i_ovf_clr,
  output logic                o_evt_valid,
  output logic [ID_W-1:0]     o_evt_id,
  output logic                o_evt_rise,
  output logic [NUM_CH-1:0]   o_pending,
  output logic [NUM_CH-1:0]   o_overflow
`ifdef TIMER_EVT_TIMESTAMP_EN
  , output logic [TS_W-1:0]   o_evt_ts
`endif
);

  if (NUM_CH < 2 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("timer_event_scheduler: NUM_CH out of range");
  end

  sched_state_e      state, state_nxt;
  logic [ID_W-1:0]   ptr, ptr_nxt;
  logic [ID_W-1:0]   evt_id_nxt, pick_id, scan_idx;
  logic              evt_rise_nxt, pick_found, accept;
  logic [NUM_CH-1:0] ch_rise, ch_accept, ch_offered, eligible;

  assign o_evt_valid = (state == OFFER);
  assign accept      = o_evt_valid & i_evt_ready;
  // Channels already disabled are skipped so a dying pending bit is never offered.
  assign eligible    = o_pending & i_ch_en;

`ifdef TIMER_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] evt_ts_nxt;
  logic [TS_W-1:0] ch_ts [NUM_CH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ts_cnt <= '0;
    else          ts_cnt <= ts_cnt + 1'b1;
  end
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_offered[c] = o_evt_valid && (o_evt_id == ID_W'(c));
    assign ch_accept[c]  = accept && (o_evt_id == ID_W'(c));

    timer_edge_capture #(
      .SYNC_STAGES (SYNC_STAGES)
`ifdef TIMER_EVT_TIMESTAMP_EN
      , .TS_W      (TS_W)
`endif
    ) u_cap (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .sig      (i_ch_sig[c]),
      .en       (i_ch_en[c]),
      .edge_sel (i_edge_sel[2*c +: 2]),
      .offered  (ch_offered[c]),
      .accept   (ch_accept[c]),
      .ovf_clr  (i_ovf_clr[c]),
`ifdef TIMER_EVT_TIMESTAMP_EN
      .ts_now   (ts_cnt),
      .ts       (ch_ts[c]),
`endif
      .pending  (o_pending[c]),
      .rise     (ch_rise[c]),
      .overflow (o_overflow[c])
    );
  end

  // Scan from the far end so the last hit written is the nearest one at or after ptr.
  // NOTE: every combinational output is given a default first so no path infers a latch.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      scan_idx = ID_W'(wrap_add(int'(ptr), i, NUM_CH));
      if (eligible[scan_idx]) begin
        pick_found = 1'b1;
        pick_id    = scan_idx;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    evt_id_nxt   = o_evt_id;
    evt_rise_nxt = o_evt_rise;
`ifdef TIMER_EVT_TIMESTAMP_EN
    evt_ts_nxt   = o_evt_ts;
`endif
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt    = OFFER;
          evt_id_nxt   = pick_id;
          evt_rise_nxt = ch_rise[pick_id];
`ifdef TIMER_EVT_TIMESTAMP_EN
          evt_ts_nxt   = ch_ts[pick_id];
`endif
        end
      end
      OFFER: begin
        if (i_evt_ready) begin
          state_nxt = IDLE;
          ptr_nxt   = ID_W'(wrap_add(int'(o_evt_id), 1, NUM_CH));
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      o_evt_id   <= '0;
      o_evt_rise <= 1'b0;
`ifdef TIMER_EVT_TIMESTAMP_EN
      o_evt_ts   <= '0;
`endif
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      o_evt_id   <= evt_id_nxt;
      o_evt_rise <= evt_rise_nxt;
`ifdef TIMER_EVT_TIMESTAMP_EN
      o_evt_ts   <= evt_ts_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_timer_event_scheduler.sv
// Directed bench for timer_event_scheduler at NUM_CH=4, SYNC_STAGES=2.
module tb_timer_event_scheduler;

  localparam int NUM_CH = 4;
  localparam int ID_W   = 2;

  logic                i_clk = 1'b0;
  logic                i_rst_n = 1'b0;
  logic [NUM_CH-1:0]   i_ch_sig = '0;
  logic [NUM_CH-1:0]   i_ch_en = '0;
  logic [2*NUM_CH-1:0] i_edge_sel = '0;
  logic                i_evt_ready = 1'b0;
  logic [NUM_CH-1:0]   i_ovf_clr = '0;
  logic                o_evt_valid;
  logic [ID_W-1:0]     o_evt_id;
  logic                o_evt_rise;
  logic [NUM_CH-1:0]   o_pending;
  logic [NUM_CH-1:0]   o_overflow;
`ifdef TIMER_EVT_TIMESTAMP_EN
  logic [15:0]         o_evt_ts;
  logic [15:0]         ts_model;
`endif

  int vectors = 0;
  int errors  = 0;

  timer_event_scheduler #(.NUM_CH(NUM_CH), .SYNC_STAGES(2)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_ch_sig    (i_ch_sig),
    .i_ch_en     (i_ch_en),
    .i_edge_sel  (i_edge_sel),
    .i_evt_ready (i_evt_ready),
    .i_ovf_clr   (i_ovf_clr),
    .o_evt_valid (o_evt_valid),
    .o_evt_id    (o_evt_id),
    .o_evt_rise  (o_evt_rise),
    .o_pending   (o_pending),
    .o_overflow  (o_overflow)
`ifdef TIMER_EVT_TIMESTAMP_EN
    , .o_evt_ts  (o_evt_ts)
`endif
  );

  always #5 i_clk = ~i_clk;

`ifdef TIMER_EVT_TIMESTAMP_EN
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ts_model <= '0;
    else          ts_model <= ts_model + 1'b1;
  end
`endif

  // Steps negedges until o_evt_valid is seen; lat = max_cyc+1 on timeout.
  task automatic wait_valid(input int max_cyc, output int lat);
    lat = max_cyc + 1;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge i_clk);
      if (o_evt_valid) begin
        lat = k;
        return;
      end
    end
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    vectors++;
    if ({o_evt_valid, o_evt_id, o_evt_rise, o_pending, o_overflow} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got %h expected 000",
               {o_evt_valid, o_evt_id, o_evt_rise, o_pending, o_overflow});
    end
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    vectors++;
    if ({o_evt_valid, o_pending, o_overflow} !== 9'h000) begin
      errors++;
      $display("FAIL reset_release_quiet: got %h expected 000", {o_evt_valid, o_pending, o_overflow});
    end
  endtask

  task automatic test_basic;
    int lat;
    i_ch_en     = 4'hF;
    i_edge_sel  = 8'b01_01_01_01;
    i_evt_ready = 1'b1;
    @(negedge i_clk);
    i_ch_sig[2] = 1'b1;
    wait_valid(20, lat);
    vectors++;
    if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", lat); end
    vectors++;
    if (o_evt_id !== 2'd2) begin errors++; $display("FAIL basic_id: got %0d expected 2", o_evt_id); end
    vectors++;
    if (o_evt_rise !== 1'b1) begin errors++; $display("FAIL basic_rise: got %b expected 1", o_evt_rise); end
    vectors++;
    if (o_pending !== 4'b0100) begin errors++; $display("FAIL basic_pending: got %b expected 0100", o_pending); end
    @(negedge i_clk);
    vectors++;
    if (o_evt_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b expected 0", o_evt_valid); end
    vectors++;
    if (o_pending !== 4'b0000) begin errors++; $display("FAIL basic_pending_clr: got %b expected 0000", o_pending); end
  endtask

  task automatic test_round_robin;
    int lat;
    i_edge_sel = 8'hFF;
    i_ch_sig[3] = 1'b1;
    wait_valid(20, lat);
    vectors++;
    if (o_evt_id !== 2'd3) begin errors++; $display("FAIL rr_align_id: got %0d expected 3", o_evt_id); end
    @(negedge i_clk);
    // pointer now 0: ch0 rises, ch3 falls in the same cycle
    i_ch_sig[0] = 1'b1;
    i_ch_sig[3] = 1'b0;
    wait_valid(20, lat);
    vectors++;
    if ({o_evt_id, o_evt_rise} !== 3'b00_1) begin
      errors++; $display("FAIL rr_p0_first: got %b expected 001", {o_evt_id, o_evt_rise});
    end
    wait_valid(4, lat);
    vectors++;
    if (lat !== 2) begin errors++; $display("FAIL rr_throughput: got %0d expected 2", lat); end
    vectors++;
    if ({o_evt_id, o_evt_rise} !== 3'b11_0) begin
      errors++; $display("FAIL rr_p0_second: got %b expected 110", {o_evt_id, o_evt_rise});
    end
    @(negedge i_clk);
    i_ch_sig[0] = 1'b0;
    wait_valid(20, lat);
    vectors++;
    if (o_evt_id !== 2'd0) begin errors++; $display("FAIL rr_single_ch0: got %0d expected 0", o_evt_id); end
    @(negedge i_clk);
    // pointer now 1: ch3 must win over ch0
    i_ch_sig[0] = 1'b1;
    i_ch_sig[3] = 1'b1;
    wait_valid(20, lat);
    vectors++;
    if (o_evt_id !== 2'd3) begin errors++; $display("FAIL rr_p1_first: got %0d expected 3", o_evt_id); end
    wait_valid(4, lat);
    vectors++;
    if (o_evt_id !== 2'd0) begin errors++; $display("FAIL rr_p1_second: got %0d expected 0", o_evt_id); end
    @(negedge i_clk);
  endtask

  task automatic test_hold_overflow;
    int lat;
    int bad;
    i_edge_sel  = 8'b11_01_10_11;
    i_evt_ready = 1'b0;
    i_ch_sig[1] = 1'b1;
    repeat (5) @(negedge i_clk);
    vectors++;
    if ({o_evt_valid, o_pending} !== 5'b0) begin
      errors++; $display("FAIL sel_ignores_rise: got %b expected 00000", {o_evt_valid, o_pending});
    end
    i_ch_sig[1] = 1'b0;
    wait_valid(20, lat);
    vectors++;
    if ({o_evt_id, o_evt_rise} !== 3'b01_0) begin
      errors++; $display("FAIL fall_event: got %b expected 010", {o_evt_id, o_evt_rise});
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) i_ch_sig[1] = 1'b1;
      if (i == 4) i_ch_sig[1] = 1'b0;
      @(negedge i_clk);
      if (o_evt_valid !== 1'b1 || o_evt_id !== 2'd1 || o_evt_rise !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin errors++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad); end
    vectors++;
    if (o_overflow !== 4'b0010) begin errors++; $display("FAIL overflow_set: got %b expected 0010", o_overflow); end
    vectors++;
    if (o_pending !== 4'b0010) begin errors++; $display("FAIL hold_pending: got %b expected 0010", o_pending); end
    i_ovf_clr = 4'b0010;
    @(negedge i_clk);
    i_ovf_clr = 4'b0000;
    vectors++;
    if (o_overflow !== 4'b0000) begin errors++; $display("FAIL overflow_clr: got %b expected 0000", o_overflow); end
    i_evt_ready = 1'b1;
    @(negedge i_clk);
    vectors++;
    if ({o_evt_valid, o_pending} !== 5'b0) begin
      errors++; $display("FAIL hold_accept: got %b expected 00000", {o_evt_valid, o_pending});
    end
  endtask

  task automatic test_coincident;
    int lat;
    i_edge_sel[3:2] = 2'b11;
    i_evt_ready     = 1'b0;
    i_ch_sig[1]     = 1'b1;
    wait_valid(20, lat);
    vectors++;
    if ({o_evt_id, o_evt_rise} !== 3'b01_1) begin
      errors++; $display("FAIL coin_first: got %b expected 011", {o_evt_id, o_evt_rise});
    end
    i_ch_sig[1] = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_evt_ready = 1'b1;
    @(negedge i_clk);
    vectors++;
    if ({o_evt_valid, o_pending[1], o_overflow[1]} !== 3'b010) begin
      errors++; $display("FAIL coin_accept: got %b expected 010", {o_evt_valid, o_pending[1], o_overflow[1]});
    end
    @(negedge i_clk);
    vectors++;
    if ({o_evt_valid, o_evt_id, o_evt_rise} !== 4'b1_01_0) begin
      errors++; $display("FAIL coin_second: got %b expected 1010", {o_evt_valid, o_evt_id, o_evt_rise});
    end
    @(negedge i_clk);
    vectors++;
    if ({o_evt_valid, o_pending, o_overflow} !== 9'h000) begin
      errors++; $display("FAIL coin_done: got %h expected 000", {o_evt_valid, o_pending, o_overflow});
    end
  endtask

  task automatic test_disable;
    int lat;
    i_evt_ready = 1'b0;
    i_ch_sig[3] = 1'b0;
    wait_valid(20, lat);
    vectors++;
    if (o_evt_id !== 2'd3) begin errors++; $display("FAIL dis_offer_id: got %0d expected 3", o_evt_id); end
    i_ch_sig[0] = 1'b0;
    repeat (4) @(negedge i_clk);
    vectors++;
    if (o_pending !== 4'b1001) begin errors++; $display("FAIL dis_pending_pre: got %b expected 1001", o_pending); end
    i_ch_en = 4'b0110;
    @(negedge i_clk);
    vectors++;
    if ({o_evt_valid, o_evt_id, o_pending} !== 7'b1_11_1000) begin
      errors++; $display("FAIL dis_kept_offer: got %b expected 1111000", {o_evt_valid, o_evt_id, o_pending});
    end
    i_evt_ready = 1'b1;
    @(negedge i_clk);
    vectors++;
    if ({o_evt_valid, o_pending} !== 5'b0) begin
      errors++; $display("FAIL dis_accept: got %b expected 00000", {o_evt_valid, o_pending});
    end
    i_ch_en = 4'hF;
  endtask

  task automatic test_reset_mid_offer;
    int lat;
    int hits;
    i_evt_ready = 1'b0;
    i_ch_sig[0] = 1'b1;
    wait_valid(20, lat);
    vectors++;
    if (o_evt_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_offer: got %b expected 1", o_evt_valid); end
    #2;
    i_rst_n  = 1'b0;
    i_ch_sig = '0;
    #1;
    vectors++;
    if ({o_evt_valid, o_evt_id, o_evt_rise, o_pending, o_overflow} !== 12'h000) begin
      errors++; $display("FAIL rst_async: got %h expected 000",
                         {o_evt_valid, o_evt_id, o_evt_rise, o_pending, o_overflow});
    end
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n     = 1'b1;
    i_evt_ready = 1'b1;
    hits = 0;
    repeat (10) begin
      @(negedge i_clk);
      if (o_evt_valid || o_pending != 4'b0) hits++;
    end
    vectors++;
    if (hits !== 0) begin errors++; $display("FAIL rst_no_ghost: got %0d active cycles expected 0", hits); end
  endtask

`ifdef TIMER_EVT_TIMESTAMP_EN
  task automatic test_timestamp;
    int lat;
    int guard;
    i_rst_n     = 1'b0;
    i_evt_ready = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    guard = 0;
    while (ts_model != 16'h000E && guard < 100) begin @(negedge i_clk); guard++; end
    i_ch_sig[0] = 1'b1;
    wait_valid(20, lat);
    repeat (5) @(negedge i_clk);
    vectors++;
    if (o_evt_ts !== 16'h0010) begin errors++; $display("FAIL ts_capture: got %h expected 0010", o_evt_ts); end
    i_evt_ready = 1'b1;
    @(negedge i_clk);
    i_evt_ready = 1'b0;
    guard = 0;
    while (ts_model != 16'hFFFE && guard < 70000) begin @(negedge i_clk); guard++; end
    i_ch_sig[0] = 1'b0;
    wait_valid(20, lat);
    vectors++;
    if (o_evt_ts !== 16'h0000) begin errors++; $display("FAIL ts_wrap: got %h expected 0000", o_evt_ts); end
    i_evt_ready = 1'b1;
    @(negedge i_clk);
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_round_robin;
    test_hold_overflow;
    test_coincident;
    test_disable;
    test_reset_mid_offer;
`ifdef TIMER_EVT_TIMESTAMP_EN
    test_timestamp;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
